// File: rtl/fifo_rd_stream_16o.sv
// Turns a fixed-latency FIFO read port into a valid/ready stream with framing (m_last, beat_cnt).
// Define FIFO_RD_OREG_EN when the FIFO has its output register enabled (read latency 2 instead of 1).
module fifo_rd_stream_16o #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  rd_en,
    input  logic                  rd_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [7:0]            beat_cnt
);

`ifdef FIFO_RD_OREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif
    localparam int unsigned DEPTH = LAT + 1;
    localparam int unsigned CW    = 2;
    localparam int unsigned PW    = 2;
    localparam int unsigned OW    = 3;
    localparam logic [7:0]  LAST_BEAT = 8'(FRAME_LEN - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [LAT-1:0]        pipe;
    logic [LAT-1:0]        pipe_next;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         inflight_next;
    logic [PW-1:0]         head;
    logic [PW-1:0]         head_next;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         tail_next;
    logic [7:0]            beat_cnt_next;
    logic [DATA_WIDTH-1:0] mem [4];
    logic [OW-1:0]         occ;
    logic                  pop;
    logic                  capture;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Shift register of issued reads; the oldest bit marks a word landing on rd_data this cycle.
`ifdef FIFO_RD_OREG_EN
    assign inflight      = CW'(pipe[0]) + CW'(pipe[1]);
    assign pipe_next     = {pipe[0], rd_en};
    assign inflight_next = CW'(pipe_next[0]) + CW'(pipe_next[1]);
`else
    assign inflight      = CW'(pipe[0]);
    assign pipe_next     = rd_en;
    assign inflight_next = CW'(pipe_next[0]);
`endif

    assign capture = pipe[LAT-1];
    assign m_valid = rd_rst_n && (state == S_STREAM);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? mem[head] : '0;
    assign m_last  = m_valid && (beat_cnt == LAST_BEAT);

    // Read only if the word is guaranteed a slot after accounting for reads still in flight.
    assign occ   = OW'(count) + OW'(inflight) - OW'(pop);
    assign rd_en = rd_rst_n && !rd_empty && (occ < OW'(DEPTH));

    always_comb begin
        count_next    = count;
        head_next     = head;
        tail_next     = tail;
        beat_cnt_next = beat_cnt;
        state_next    = S_IDLE;

        if (capture) begin
            tail_next = ptr_inc(tail);
        end
        if (pop) begin
            head_next     = ptr_inc(head);
            beat_cnt_next = (beat_cnt == LAST_BEAT) ? 8'd0 : beat_cnt + 8'd1;
        end
        count_next = count + CW'(capture) - CW'(pop);

        if (count_next != '0) begin
            state_next = S_STREAM;
        end else if (inflight_next != '0) begin
            state_next = S_FILL;
        end else begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            pipe     <= '0;
            head     <= '0;
            tail     <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            pipe     <= pipe_next;
            head     <= head_next;
            tail     <= tail_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else if (capture) begin
            mem[tail] <= rd_data;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_16o.sv
// Directed bench for fifo_rd_stream_16o with a behavioural fixed-latency FIFO; words are index+1.
// Honours FIFO_RD_OREG_EN so the FIFO model latency matches the build.
module tb_fifo_rd_stream_16o;

`ifdef FIFO_RD_OREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif
    localparam int unsigned DEPTH = LAT + 1;

    logic        rd_clk;
    logic        rd_rst_n;
    logic        rd_en;
    logic        rd_empty;
    logic [15:0] rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic [7:0]  beat_cnt;

    int n_checks;
    int n_errors;
    int avail;
    int rptr;
    int n_beats;
    int exp_beat;
    int word_gap;
    int uflow;
    logic [15:0] q1;
    logic [15:0] q2;

    fifo_rd_stream_16o dut (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .rd_en    (rd_en),
        .rd_empty (rd_empty),
        .rd_data  (rd_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .beat_cnt (beat_cnt)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural FIFO: pops on rd_en, data appears LAT cycles later.
    assign rd_empty = (rptr >= avail);
    assign rd_data  = (LAT == 2) ? q2 : q1;

    always @(posedge rd_clk) begin
        q2 <= q1;
        if (rd_en) begin
            q1   <= 16'(rptr + 1);
            rptr <= rptr + 1;
        end
    end

    // Beat monitor: words in order (index+1, shifted past any discarded word), beat_cnt mod 4.
    always @(negedge rd_clk) begin
        if (rd_en && rd_empty) uflow++;
        if (!rd_rst_n) exp_beat = 0;
        if (m_valid && m_ready) begin
            check("beat_data", 32'(m_data), 32'(n_beats + 1 + word_gap));
            check("beat_cnt", 32'(beat_cnt), 32'(exp_beat));
            check("beat_last", 32'(m_last), 32'(exp_beat == 3));
            n_beats++;
            exp_beat = (exp_beat == 3) ? 0 : exp_beat + 1;
        end
    end

    task automatic wait_beats(input string tag, input int target, input int budget);
        int c;
        c = 0;
        while (n_beats < target && c < budget) begin
            @(negedge rd_clk);
            c++;
        end
        check(tag, 32'(n_beats), 32'(target));
    endtask

    initial begin
        int pulses;
        int c;
        logic found;
        n_checks = 0;
        n_errors = 0;
        rptr     = 0;
        avail    = 8;
        n_beats  = 0;
        exp_beat = 0;
        word_gap = 0;
        uflow    = 0;
        q1       = '0;
        q2       = '0;
        rd_rst_n = 1'b0;
        m_ready  = 1'b1;

        // Reset with 8 words waiting: nothing may be read or presented.
        repeat (3) begin
            @(negedge rd_clk);
            check("rst_rd_en", 32'(rd_en), 32'd0);
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_m_last", 32'(m_last), 32'd0);
            check("rst_m_data", 32'(m_data), 32'd0);
        end
        @(posedge rd_clk);
        #1 rd_rst_n = 1'b1;

        // First read in the release cycle, first beat at cycle LAT+1, then 8 back-to-back beats.
        for (int cyc = 0; cyc <= int'(LAT) + 9; cyc++) begin
            @(negedge rd_clk);
            if (cyc == 0) check("first_rd_en", 32'(rd_en), 32'd1);
            if (cyc == int'(LAT) + 1) check("first_word", 32'(m_data), 32'h0001);
            check("stream_valid", 32'(m_valid), 32'((cyc >= int'(LAT) + 1) && (cyc <= int'(LAT) + 8)));
        end
        check("burst_beats", 32'(n_beats), 32'd8);
        check("burst_idle_rd_en", 32'(rd_en), 32'd0);

        // Back-pressure: only DEPTH reads may be issued while stalled.
        @(posedge rd_clk);
        #1;
        m_ready = 1'b0;
        avail   = 16;
        pulses  = 0;
        repeat (10) begin
            @(negedge rd_clk);
            if (rd_en) pulses++;
        end
        check("stall_rd_pulses", 32'(pulses), 32'(DEPTH));
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'h0009);
        check("stall_last", 32'(m_last), 32'd0);
        @(posedge rd_clk);
        #1 m_ready = 1'b1;
        wait_beats("stall_drain", 16, 60);

        // Single word: one read, one beat, back to idle.
        @(posedge rd_clk);
        #1 avail = 17;
        pulses = 0;
        repeat (8) begin
            @(negedge rd_clk);
            if (rd_en) pulses++;
        end
        check("single_rd_pulses", 32'(pulses), 32'd1);
        check("single_beats", 32'(n_beats), 32'd17);
        check("single_idle_valid", 32'(m_valid), 32'd0);
        check("single_beat_cnt", 32'(beat_cnt), 32'd1);

        // Reset the cycle after a read: word 18 is lost, stream resumes at 19 with beat_cnt 0.
        @(posedge rd_clk);
        #1 avail = 21;
        found = 1'b0;
        c = 0;
        while (!found && c < 10) begin
            @(negedge rd_clk);
            if (rd_en) found = 1'b1;
            c++;
        end
        check("inflight_rd_seen", 32'(found), 32'd1);
        word_gap = 1;
        @(posedge rd_clk);
        #1 rd_rst_n = 1'b0;
        @(negedge rd_clk);
        check("pulse_rd_en", 32'(rd_en), 32'd0);
        check("pulse_m_valid", 32'(m_valid), 32'd0);
        @(posedge rd_clk);
        #1 rd_rst_n = 1'b1;
        @(negedge rd_clk);
        check("post_rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("post_rst_rd_en", 32'(rd_en), 32'd1);
        wait_beats("post_rst_drain", 20, 40);

        // Random back-pressure over 1000 words.
        @(posedge rd_clk);
        #1 avail = 1021;
        c = 0;
        while (n_beats < 1020 && c < 20000) begin
            @(posedge rd_clk);
            #1 m_ready = 1'($urandom_range(0, 1));
            c++;
        end
        m_ready = 1'b1;
        wait_beats("random_total", 1020, 20);
        repeat (6) @(negedge rd_clk);
        check("final_idle_valid", 32'(m_valid), 32'd0);
        check("final_idle_rd_en", 32'(rd_en), 32'd0);
        check("no_underflow", 32'(uflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
